// File: rtl/relay_memory_responder_if.sv
// rtl/relay_memory_responder_if.sv - address/data bus and MemRead/MemWrite handshake between sequencer and memory responder
//
// Purpose: bundles the sequencer-facing bus of the relay memory responder.
// Signals:
//   addressBusPins [15:0]  address placed by the sequencer
//   dataBusIn      [7:0]   write data sampled by the responder
//   dataBusOut     [7:0]   read data driven by the responder
//   dataBusOe              responder owns the data bus, dataBusOut valid
//   MemReadpin             read request level, held until memAck
//   MemWritepin            write request level, held until memAck
//   memAck                 one-cycle completion pulse
//   memBusy                transaction in flight
//   memConflict            one-cycle pulse, both requests seen high in idle
// Modports: master = sequencer side, slave = responder side.

interface relay_memory_responder_if;
   logic [15:0] addressBusPins;
   logic [7:0]  dataBusIn;
   logic [7:0]  dataBusOut;
   logic        dataBusOe;
   logic        MemReadpin;
   logic        MemWritepin;
   logic        memAck;
   logic        memBusy;
   logic        memConflict;

   modport master (
      output addressBusPins, dataBusIn, MemReadpin, MemWritepin,
      input  dataBusOut, dataBusOe, memAck, memBusy, memConflict
   );

   modport slave (
      input  addressBusPins, dataBusIn, MemReadpin, MemWritepin,
      output dataBusOut, dataBusOe, memAck, memBusy, memConflict
   );
endinterface

// File: rtl/relay_memory_responder.sv
// rtl/relay_memory_responder.sv - memory-side responder with programmable wait states
//
// Purpose: samples a single read or write request from the sequencer,
// waits WAIT_CYCLES edges to emulate relay latency, then drives read data
// or commits write data and pulses memAck.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset (memory contents are preserved)
//   bus    relay_memory_responder_if.slave, see the interface for signals
// Parameters:
//   DEPTH_LOG2     log2 of implemented bytes; higher addresses are unmapped
//   WAIT_CYCLES    wait states between capture and completion (0..15)
//   UNMAPPED_DATA  value returned for reads of unmapped addresses

module relay_memory_responder #(
   parameter int         DEPTH_LOG2    = 10,
   parameter int         WAIT_CYCLES   = 2,
   parameter logic [7:0] UNMAPPED_DATA = 8'hFF
) (
   input logic                     clk,
   input logic                     reset,
   relay_memory_responder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RD_DRIVE,
      S_WR_HOLD
   } state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [15:0] cap_addr;
   logic [7:0]  cap_data;
   logic        cap_write;
   logic        cap_mapped;
   logic        req_held;

   // Contents start at zero and are deliberately left untouched by reset.
   logic [7:0] mem [2**DEPTH_LOG2] = '{default: 8'h00};

   assign cap_mapped = (cap_addr >> DEPTH_LOG2) == 16'd0;
   // The request that was captured must stay asserted for the whole wait.
   assign req_held   = cap_write ? bus.MemWritepin : bus.MemReadpin;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         wait_cnt        <= 4'd0;
         bus.dataBusOut  <= 8'h00;
         bus.dataBusOe   <= 1'b0;
         bus.memAck      <= 1'b0;
         bus.memBusy     <= 1'b0;
         bus.memConflict <= 1'b0;
      end else begin
         bus.memAck      <= 1'b0;
         bus.memConflict <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.MemReadpin && bus.MemWritepin) begin
                  bus.memConflict <= 1'b1;
               end else if (bus.MemReadpin || bus.MemWritepin) begin
                  cap_addr    <= bus.addressBusPins;
                  cap_data    <= bus.dataBusIn;
                  cap_write   <= bus.MemWritepin;
                  wait_cnt    <= 4'(WAIT_CYCLES);
                  bus.memBusy <= 1'b1;
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!req_held) begin
                  bus.memBusy <= 1'b0;
                  state       <= S_IDLE;
               end else if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  bus.memAck <= 1'b1;
                  if (cap_write) begin
                     if (cap_mapped) begin
                        mem[cap_addr[DEPTH_LOG2-1:0]] <= cap_data;
                     end
                     state <= S_WR_HOLD;
                  end else begin
                     bus.dataBusOut <= cap_mapped ? mem[cap_addr[DEPTH_LOG2-1:0]]
                                                  : UNMAPPED_DATA;
                     bus.dataBusOe  <= 1'b1;
                     state          <= S_RD_DRIVE;
                  end
               end
            end
            S_RD_DRIVE: begin
               if (!bus.MemReadpin) begin
                  bus.dataBusOe <= 1'b0;
                  bus.memBusy   <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            S_WR_HOLD: begin
               // Wait for the write level to drop so one request commits once.
               if (!bus.MemWritepin) begin
                  bus.memBusy <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_relay_memory_responder.sv
// tb/tb_relay_memory_responder.sv - bench for relay_memory_responder with WAIT_CYCLES=0 and WAIT_CYCLES=2 instances

module tb_relay_memory_responder;

   logic        clk;
   logic        t_rst;
   logic        t_rd;
   logic        t_wr;
   logic [15:0] t_addr;
   logic [7:0]  t_din;

   int vectors     = 0;
   int miscompares = 0;

   relay_memory_responder_if if0 ();
   relay_memory_responder_if if2 ();

   assign if0.MemReadpin     = t_rd;
   assign if0.MemWritepin    = t_wr;
   assign if0.addressBusPins = t_addr;
   assign if0.dataBusIn      = t_din;
   assign if2.MemReadpin     = t_rd;
   assign if2.MemWritepin    = t_wr;
   assign if2.addressBusPins = t_addr;
   assign if2.dataBusIn      = t_din;

   relay_memory_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .UNMAPPED_DATA(8'hFF)) u_w0 (
      .clk   (clk),
      .reset (t_rst),
      .bus   (if0)
   );

   relay_memory_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .UNMAPPED_DATA(8'hFF)) u_w2 (
      .clk   (clk),
      .reset (t_rst),
      .bus   (if2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level reference: a request is "pending" for a number of
   // edges; it completes when it has survived WAIT_CYCLES+1 edges.
   localparam int P_IDLE  = 0;
   localparam int P_PEND  = 1;
   localparam int P_DRIVE = 2;
   localparam int P_HOLD  = 3;

   logic [7:0]  ref_mem [2][1024];
   int          m_phase [2];
   int          m_age   [2];
   logic        m_kind  [2];
   logic [15:0] m_addr  [2];
   logic [7:0]  m_data  [2];
   logic        m_ack   [2];
   logic        m_busy  [2];
   logic        m_conf  [2];
   logic        m_oe    [2];
   logic [7:0]  m_dout  [2];
   logic        m_dchk  [2];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input int k, input int w);
      m_ack[k]  = 1'b0;
      m_conf[k] = 1'b0;
      m_dchk[k] = 1'b0;
      if (t_rst) begin
         m_phase[k] = P_IDLE;
         m_busy[k]  = 1'b0;
         m_oe[k]    = 1'b0;
         m_dout[k]  = 8'h00;
         m_dchk[k]  = 1'b1;
         return;
      end
      case (m_phase[k])
         P_IDLE: begin
            if (t_rd && t_wr) m_conf[k] = 1'b1;
            else if (t_rd || t_wr) begin
               m_kind[k]  = t_wr;
               m_addr[k]  = t_addr;
               m_data[k]  = t_din;
               m_age[k]   = 0;
               m_busy[k]  = 1'b1;
               m_phase[k] = P_PEND;
            end
         end
         P_PEND: begin
            if (!(m_kind[k] ? t_wr : t_rd)) begin
               m_busy[k]  = 1'b0;
               m_phase[k] = P_IDLE;
            end else begin
               m_age[k]++;
               if (m_age[k] == w + 1) begin
                  m_ack[k] = 1'b1;
                  if (m_kind[k]) begin
                     if (m_addr[k] < 16'd1024) ref_mem[k][m_addr[k][9:0]] = m_data[k];
                     m_phase[k] = P_HOLD;
                  end else begin
                     m_dout[k]  = (m_addr[k] < 16'd1024) ? ref_mem[k][m_addr[k][9:0]] : 8'hFF;
                     m_oe[k]    = 1'b1;
                     m_phase[k] = P_DRIVE;
                  end
               end
            end
         end
         P_DRIVE: if (!t_rd) begin
            m_oe[k]    = 1'b0;
            m_busy[k]  = 1'b0;
            m_phase[k] = P_IDLE;
         end
         default: if (!t_wr) begin
            m_busy[k]  = 1'b0;
            m_phase[k] = P_IDLE;
         end
      endcase
   endtask

   // Compare process: advance the reference on every edge, sample 1 time unit later.
   always @(posedge clk) begin
      model_step(0, 0);
      model_step(1, 2);
      #1;
      chk("w0_ack",  8'(if0.memAck),      8'(m_ack[0]));
      chk("w0_busy", 8'(if0.memBusy),     8'(m_busy[0]));
      chk("w0_conf", 8'(if0.memConflict), 8'(m_conf[0]));
      chk("w0_oe",   8'(if0.dataBusOe),   8'(m_oe[0]));
      if (m_oe[0] || m_dchk[0]) chk("w0_dout", if0.dataBusOut, m_dout[0]);
      chk("w2_ack",  8'(if2.memAck),      8'(m_ack[1]));
      chk("w2_busy", 8'(if2.memBusy),     8'(m_busy[1]));
      chk("w2_conf", 8'(if2.memConflict), 8'(m_conf[1]));
      chk("w2_oe",   8'(if2.dataBusOe),   8'(m_oe[1]));
      if (m_oe[1] || m_dchk[1]) chk("w2_dout", if2.dataBusOut, m_dout[1]);
   end

   task automatic cyc(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
      t_rd = rd; t_wr = wr; t_addr = a; t_din = d;
      @(posedge clk); #2;
   endtask

   function automatic logic ack_of(input int k);
      return (k == 0) ? if0.memAck : if2.memAck;
   endfunction

   // Raise a request, hold it until instance k acks, then release for one cycle.
   task automatic xact(input int k, input logic wr, input logic [15:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rdata, output logic oe_ack,
                       output logic oe_after);
      lat = -1; rdata = 8'h00; oe_ack = 1'b0;
      t_rd = !wr; t_wr = wr; t_addr = a; t_din = d;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #2;
         if (ack_of(k)) begin
            lat    = n - 1;
            rdata  = (k == 0) ? if0.dataBusOut : if2.dataBusOut;
            oe_ack = (k == 0) ? if0.dataBusOe : if2.dataBusOe;
            break;
         end
      end
      chk("ack_seen", 8'(lat >= 0), 8'h01);
      cyc(1'b0, 1'b0, a, d);
      oe_after = (k == 0) ? if0.dataBusOe : if2.dataBusOe;
   endtask

   function automatic logic [15:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 16'(16'h0000 + $urandom_range(0, 7));
         1:       return 16'(16'h03F8 + $urandom_range(0, 7));
         2:       return 16'(16'h0400 + $urandom_range(0, 7));
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      int          lat;
      logic [7:0]  rd_v;
      logic        oe_a;
      logic        oe_b;
      int          n_conf;
      int          n_ack;

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 1024; i++) ref_mem[k][i] = 8'h00;
         m_phase[k] = P_IDLE; m_age[k] = 0; m_kind[k] = 1'b0; m_addr[k] = 16'h0;
         m_data[k] = 8'h0; m_ack[k] = 1'b0; m_busy[k] = 1'b0; m_conf[k] = 1'b0;
         m_oe[k] = 1'b0; m_dout[k] = 8'h0; m_dchk[k] = 1'b0;
      end
      t_rst = 1'b1; t_rd = 1'b0; t_wr = 1'b0; t_addr = 16'h0; t_din = 8'h0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      chk("reset_busy", 8'(if2.memBusy), 8'h00);
      chk("reset_dout", if2.dataBusOut, 8'h00);
      t_rst = 1'b0;
      cyc(1'b0, 1'b0, 16'h0, 8'h0);

      // Write then read back, WAIT_CYCLES=2 latency and bus ownership.
      xact(1, 1'b1, 16'h0005, 8'hA5, lat, rd_v, oe_a, oe_b);
      chk("wr_latency", 8'(lat), 8'd3);
      xact(1, 1'b0, 16'h0005, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("rd_latency", 8'(lat), 8'd3);
      chk("rd_data_A5", rd_v, 8'hA5);
      chk("rd_oe_at_ack", 8'(oe_a), 8'h01);
      chk("rd_oe_after_drop", 8'(oe_b), 8'h00);

      // Unmapped accesses, no aliasing onto address 0.
      xact(1, 1'b0, 16'h8000, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("unmapped_rd", rd_v, 8'hFF);
      xact(1, 1'b1, 16'h8000, 8'h11, lat, rd_v, oe_a, oe_b);
      xact(1, 1'b0, 16'h0000, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("no_alias", rd_v, 8'h00);

      // Both requests high for three cycles.
      n_conf = 0; n_ack = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 16'h0005, 8'h5A);
         n_conf += int'(if2.memConflict);
         n_ack  += int'(if2.memAck);
      end
      cyc(1'b0, 1'b0, 16'h0005, 8'h00);
      chk("conflict_pulses", 8'(n_conf), 8'd3);
      chk("conflict_no_ack", 8'(n_ack), 8'd0);
      xact(1, 1'b0, 16'h0005, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("conflict_mem_kept", rd_v, 8'hA5);

      // Write request dropped during the wait.
      n_ack = 0;
      cyc(1'b0, 1'b1, 16'h0010, 8'h3C);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 16'h0010, 8'h3C);
         n_ack += int'(if2.memAck);
      end
      chk("abort_no_ack", 8'(n_ack), 8'd0);
      xact(1, 1'b0, 16'h0010, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("abort_no_write", rd_v, 8'h00);

      // Reset in the middle of a write.
      cyc(1'b0, 1'b1, 16'h0020, 8'h77);
      t_rst = 1'b1;
      cyc(1'b0, 1'b1, 16'h0020, 8'h77);
      chk("rst_mid_busy", 8'(if2.memBusy), 8'h00);
      chk("rst_mid_ack", 8'(if2.memAck), 8'h00);
      chk("rst_mid_oe", 8'(if2.dataBusOe), 8'h00);
      t_rst = 1'b0;
      cyc(1'b0, 1'b0, 16'h0020, 8'h00);
      xact(1, 1'b0, 16'h0020, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("rst_no_commit", rd_v, 8'h00);
      xact(1, 1'b0, 16'h0005, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("rst_mem_survives", rd_v, 8'hA5);

      // WAIT_CYCLES=0: held read across an address change executes once.
      lat = -1;
      t_rd = 1'b1; t_wr = 1'b0; t_addr = 16'h0001;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #2;
         if (if0.memAck) begin lat = n - 1; break; end
      end
      chk("w0_first_latency", 8'(lat), 8'd1);
      n_ack = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 16'h0002, 8'h00);
         n_ack += int'(if0.memAck);
      end
      chk("w0_held_no_repeat", 8'(n_ack), 8'd0);
      cyc(1'b0, 1'b0, 16'h0002, 8'h00);
      xact(0, 1'b0, 16'h0002, 8'h00, lat, rd_v, oe_a, oe_b);
      chk("w0_second_latency", 8'(lat), 8'd1);
      repeat (6) cyc(1'b0, 1'b0, 16'h0000, 8'h00);

      // Randomized traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         t_rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) t_rd = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) t_wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) t_addr = pick_addr();
         t_din = 8'($urandom);
         @(posedge clk); #2;
      end
      t_rst = 1'b0; t_rd = 1'b0; t_wr = 1'b0;
      repeat (3) begin @(posedge clk); #2; end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/relay_memory_responder.md
Name: relay_memory_responder

Overview:
- Memory-side responder for the CPU's address/data buses and the MemRead/MemWrite control pair.
- Sits opposite the sequencer. The sequencer places an address on the 16-bit address bus and raises one request line. This block samples the request, inserts programmable wait states to emulate relay/memory latency, then drives the read data onto the data bus or commits the write data. It signals completion with a one-cycle acknowledge.

Parameters:
- DEPTH_LOG2, 10, log2 of implemented byte locations; addresses at or above 2**DEPTH_LOG2 are unmapped.
- WAIT_CYCLES, 2, wait states inserted between request capture and completion; legal range 0..15.
- UNMAPPED_DATA, 8'hFF, value returned on a read of an unmapped address.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addressBusPins  in  16  address from the address bus.
- dataBusIn  in  8  data bus value sampled for writes.
- dataBusOut  out  8  read data driven to the data bus.
- dataBusOe  out  1  high while dataBusOut is valid and owns the data bus.
- MemReadpin  in  1  read request, level, held by the sequencer until ack is seen.
- MemWritepin  in  1  write request, level, held by the sequencer until ack is seen.
- memAck  out  1  one-cycle completion pulse.
- memBusy  out  1  high from request capture until return to IDLE.
- memConflict  out  1  one-cycle pulse when both requests are sampled high in IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, dataBusOut=0, dataBusOe=0, memAck=0, memBusy=0, memConflict=0, wait counter=0.
  - Reset does not clear the memory array. The array initialises to all zeros at time 0.
  - Reset mid-transaction aborts it: no write commit, no ack.
- States: IDLE, WAIT, RD_DRIVE, WR_HOLD.
- IDLE:
  - Exactly one request high at an edge: capture addressBusPins. For a write, also capture dataBusIn. Load the counter with WAIT_CYCLES, set memBusy=1 and go to WAIT.
  - Both requests high: stay IDLE, pulse memConflict for one cycle. Nothing is captured or committed.
  - memConflict re-pulses on every edge at which both requests are still high.
- WAIT:
  - Counter>0: decrement the counter.
  - Counter==0: complete the transaction.
  - The captured request is re-checked every WAIT edge. If it has dropped, abort to IDLE: memBusy=0, no ack, no write.
- Completion timing: memAck rises exactly WAIT_CYCLES+1 edges after the capture edge. WAIT_CYCLES=0 means ack on the edge after capture.
- Read completion:
  - Mapped address: dataBusOut = mem[captured address[DEPTH_LOG2-1:0]].
  - Unmapped address: dataBusOut = UNMAPPED_DATA.
  - Set dataBusOe=1 and memAck=1 for one cycle, then go to RD_DRIVE.
- Write completion:
  - Mapped address: mem[...] = captured data.
  - Unmapped address: write silently dropped.
  - Set memAck=1 for one cycle, then go to WR_HOLD.
- RD_DRIVE:
  - Hold dataBusOut/dataBusOe while MemReadpin=1.
  - On the first edge sampling MemReadpin=0: dataBusOe=0, memBusy=0, go to IDLE.
  - dataBusOut keeps its last value and is don't-care while Oe=0.
- WR_HOLD: wait for MemWritepin=0, then memBusy=0 and go to IDLE.
  - This prevents one held request from executing twice.
- Request-line changes after capture:
  - Address/data changes after capture are ignored; the captured values are used.
  - A new request is only accepted from IDLE, so the minimum gap between transactions is one idle cycle.
- Write-then-read to the same address returns the new data: the commit happens at the ack edge, before any later read capture.

Test Plan:
- WAIT_CYCLES=2. Write addr 16'h0005 data 8'hA5, hold MemWritepin until ack. Then read 16'h0005 -> memAck 3 edges after each capture; read returns dataBusOut=8'hA5 with Oe=1; Oe drops the edge after MemReadpin falls.
- Read unmapped addr 16'h8000 (DEPTH_LOG2=10) -> dataBusOut=8'hFF, Oe=1, memAck one pulse. Write 8'h11 to 16'h8000 then read 16'h0000 -> returns 8'h00 (no aliasing).
- MemReadpin and MemWritepin both high for 3 cycles in IDLE -> memConflict pulses 3 times, memAck never asserts, memory unchanged.
- Write 8'h3C to 16'h0010, drop MemWritepin after 1 cycle (WAIT_CYCLES=2) -> abort to IDLE, no ack; subsequent read of 16'h0010 returns 8'h00.
- Assert reset during WAIT of a write of 8'h77 to 16'h0020 -> next cycle all outputs 0, state IDLE; read of 16'h0020 returns prior contents. Contents written before the reset survive it.
- WAIT_CYCLES=0, back-to-back reads of 16'h0001 and 16'h0002 with requests held continuously across the address change -> only the first executes. After MemReadpin drops for one cycle, the second read acks on the edge after its capture.
